// File: rtl/bnn_window_gen_if.sv
// Pixel-in / window-out streaming bus of the 3x3 window generator.
// The slave side is the generator, the master side is whoever feeds pixels and drains windows.
interface bnn_window_gen_if #(
    parameter int unsigned CH = 3
) ();
    logic            pix_valid;
    logic            pix_ready;
    logic [CH-1:0]   pix_data;
    logic            win_valid;
    logic            win_ready;
    logic [9*CH-1:0] win_data;
    logic            win_last;

    modport master (
        output pix_valid,
        output pix_data,
        output win_ready,
        input  pix_ready,
        input  win_valid,
        input  win_data,
        input  win_last
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  win_ready,
        output pix_ready,
        output win_valid,
        output win_data,
        output win_last
    );
endinterface

// File: rtl/bnn_window_gen.sv
// Streaming 3x3 sliding-window generator for CH-channel binary feature maps.
// Raster-order pixels in, one registered 3x3xCH window out per valid position
// (stride 1, no padding). Two line buffers hold the previous two rows.
// Window tap k = 3*r + s (r = row offset, 0 = top; s = column offset, 0 = left)
// occupies win_data[k*CH +: CH].
module bnn_window_gen #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned CH    = 3
) (
    input logic             clk,
    input logic             rstn,  // synchronous, active-high despite the name
    bnn_window_gen_if.slave bus
);
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic             accept;
    logic             complete;
    logic             frame_end_pix;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    logic [9*CH-1:0]  win_data_q, win_data_d;
    logic [9*CH-1:0]  tap_flat;

    // Line buffers: lb0 holds row-2, lb1 holds row-1, both indexed by column.
    logic [CH-1:0]    lb0_q [IMG_W];
    logic [CH-1:0]    lb1_q [IMG_W];
    // Running 3x3 window, indexed by tap k = 3*r + s.
    logic [CH-1:0]    tap_q [9];
    logic [CH-1:0]    tap_d [9];

    // Single output register: a new pixel may enter whenever the slot empties this cycle.
    assign bus.pix_ready = !win_valid_q || bus.win_ready;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
    assign bus.win_last  = win_last_q;

    assign accept        = bus.pix_valid && bus.pix_ready;
    // Only positions whose full 3x3 neighbourhood lies in the current frame emit,
    // so stale taps from earlier rows or frames never reach the output.
    assign complete      = accept && (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));
    assign frame_end_pix = (col_q == COL_MAX) && (row_q == ROW_MAX);

    // Window shift: columns move left, new right column comes from lb0, lb1 and the pixel.
    always_comb begin
        tap_d[0] = tap_q[1];
        tap_d[1] = tap_q[2];
        tap_d[2] = lb0_q[col_q];
        tap_d[3] = tap_q[4];
        tap_d[4] = tap_q[5];
        tap_d[5] = lb1_q[col_q];
        tap_d[6] = tap_q[7];
        tap_d[7] = tap_q[8];
        tap_d[8] = bus.pix_data;
        tap_flat = '0;
        for (int k = 0; k < 9; k++) begin
            tap_flat[k*CH +: CH] = tap_d[k];
        end
    end

    // Next-state for raster counters and the output slot.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_data_d  = win_data_q;
        if (accept) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (complete) begin
            // Either the slot was empty or the old window retires this same cycle.
            win_valid_d = 1'b1;
            win_data_d  = tap_flat;
            win_last_d  = frame_end_pix;
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_data_q  <= win_data_d;
        end
    end

    // Pixel storage needs no reset; it is always refilled before being emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            tap_q        <= tap_d;
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= bus.pix_data;
        end
    end
endmodule
